// File: rtl/prog_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : prog_sequencer
//  Description : Fetch/sequencing controller for the 20-bit instruction LUT.
//                Drives the 9-bit instruction pointer, decodes branch and
//                DONE opcodes, evaluates branch conditions against the
//                datapath compare flags and launches one of three resident
//                programs. Reports completion, a saturating RUN-cycle count
//                and a watchdog timeout.
//  Ports       : clk, rst_n          - clock, async active-low reset
//                start, prog_sel     - launch request / program select (3 illegal)
//                inst                - instruction at iptr (combinational from LUT)
//                flag_eq/lt/gt       - datapath compare flags
//                stall               - datapath busy, freezes iptr
//                iptr, inst_valid    - fetch address / instruction live
//                busy, done          - running / one-cycle completion pulse
//                timeout, bad_sel    - sticky status flags
//                cycles              - saturating RUN-cycle count
//  Revision    : 1.0 - initial release
// ============================================================================
module prog_sequencer #(
    parameter logic [8:0]  ENTRY0  = 9'd1,
    parameter logic [8:0]  ENTRY1  = 9'd25,
    parameter logic [8:0]  ENTRY2  = 9'd42,
    parameter logic [15:0] TIMEOUT = 16'd4000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [1:0]  prog_sel,
    input  logic [19:0] inst,
    input  logic        flag_eq,
    input  logic        flag_lt,
    input  logic        flag_gt,
    input  logic        stall,
    output logic [8:0]  iptr,
    output logic        inst_valid,
    output logic        busy,
    output logic        done,
    output logic        timeout,
    output logic        bad_sel,
    output logic [15:0] cycles
);

    localparam logic [4:0] OP_BE   = 5'b00111;
    localparam logic [4:0] OP_BL   = 5'b01000;
    localparam logic [4:0] OP_BG   = 5'b01001;
    localparam logic [4:0] OP_BA   = 5'b01010;
    localparam logic [4:0] OP_DONE = 5'b01110;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIN  = 2'd2
    } state_t;

    state_t      state_q;
    logic [8:0]  iptr_q;
    logic        inst_valid_q;
    logic        busy_q;
    logic        done_q;
    logic        timeout_q;
    logic        bad_sel_q;
    logic [15:0] cycles_q;

    logic [4:0]  opcode;
    logic        br_taken;
    logic [8:0]  br_target;
    logic [8:0]  entry_d;
    logic [15:0] cycles_d;
    logic        unused_off_hi;

    assign opcode = inst[19:15];

    // Offset is 15-bit two's complement, but only its low 9 bits matter:
    // the add is modulo 512 so the upper sign bits cannot change the result.
    assign br_target     = iptr_q + inst[8:0];
    assign unused_off_hi = ^inst[14:9];

    always_comb begin
        br_taken = 1'b0;
        case (opcode)
            OP_BE:   br_taken = flag_eq;
            OP_BL:   br_taken = flag_lt;
            OP_BG:   br_taken = flag_gt;
            OP_BA:   br_taken = 1'b1;
            default: br_taken = 1'b0;
        endcase
    end

    always_comb begin
        entry_d = ENTRY0;
        case (prog_sel)
            2'd1:    entry_d = ENTRY1;
            2'd2:    entry_d = ENTRY2;
            default: entry_d = ENTRY0;
        endcase
    end

    // Saturating increment of the RUN-cycle counter.
    assign cycles_d = (cycles_q == 16'hFFFF) ? cycles_q : cycles_q + 16'd1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            iptr_q       <= 9'd0;
            inst_valid_q <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            timeout_q    <= 1'b0;
            bad_sel_q    <= 1'b0;
            cycles_q     <= 16'd0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    iptr_q       <= 9'd0;
                    inst_valid_q <= 1'b0;
                    busy_q       <= 1'b0;
                    if (start) begin
                        cycles_q <= 16'd0;
                        if (prog_sel == 2'b11) begin
                            // Illegal select: report and complete without executing.
                            bad_sel_q <= 1'b1;
                            done_q    <= 1'b1;
                            state_q   <= S_FIN;
                        end else begin
                            iptr_q       <= entry_d;
                            timeout_q    <= 1'b0;
                            bad_sel_q    <= 1'b0;
                            inst_valid_q <= 1'b1;
                            busy_q       <= 1'b1;
                            state_q      <= S_RUN;
                        end
                    end
                end
                S_RUN: begin
                    cycles_q <= cycles_d;
                    if (cycles_q == TIMEOUT - 16'd1) begin
                        timeout_q    <= 1'b1;
                        done_q       <= 1'b1;
                        inst_valid_q <= 1'b0;
                        busy_q       <= 1'b0;
                        state_q      <= S_FIN;
                    end else if (stall) begin
                        iptr_q <= iptr_q;
                    end else if (opcode == OP_DONE) begin
                        done_q       <= 1'b1;
                        inst_valid_q <= 1'b0;
                        busy_q       <= 1'b0;
                        state_q      <= S_FIN;
                    end else if (br_taken) begin
                        iptr_q <= br_target;
                    end else begin
                        iptr_q <= iptr_q + 9'd1;
                    end
                end
                S_FIN: begin
                    iptr_q       <= 9'd0;
                    inst_valid_q <= 1'b0;
                    busy_q       <= 1'b0;
                    state_q      <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign iptr       = iptr_q;
    assign inst_valid = inst_valid_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign timeout    = timeout_q;
    assign bad_sel    = bad_sel_q;
    assign cycles     = cycles_q;

endmodule
`default_nettype wire
